// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

   // Originator of an in-flight read; ARB_NONE marks an empty tag slot.
   typedef enum logic [1:0] {
      ARB_NONE = 2'd0,
      ARB_DBG  = 2'd1,
      ARB_DM   = 2'd2,
      ARB_IF   = 2'd3
   } arb_id_t;

   localparam int MEM_LATENCY_DEFAULT  = 1;
   localparam int STARVE_LIMIT_DEFAULT = 4;

   // One slot of the read-tag pipeline.
   typedef struct packed {
      logic    valid;
      arb_id_t id;
   } arb_tag_t;

   // Builds a tag; an invalid tag always carries ARB_NONE so idle slots stay clean.
   function automatic arb_tag_t make_tag(input logic valid, input arb_id_t id);
      arb_tag_t t;
      t.valid = valid;
      t.id    = valid ? id : ARB_NONE;
      return t;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_tag_pipe.sv
// Fixed-depth shift register of read tags. A tag written at the input
// appears at the output exactly DEPTH cycles later, matching the memory
// read latency, so the output names the owner of the current mem_rdata.
module arb_tag_pipe
   import mem_port_arbiter_pkg::*;
#(
   parameter int DEPTH = MEM_LATENCY_DEFAULT
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic       in_valid,
   input  logic [1:0] in_id,
   output logic       out_valid,
   output logic [1:0] out_id
);

   arb_tag_t [DEPTH-1:0] stage_q;
   arb_tag_t [DEPTH-1:0] stage_d;

   // New tag enters slot 0, every other slot takes its predecessor.
   always_comb begin
      stage_d[0] = make_tag(in_valid, arb_id_t'(in_id));
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Asynchronous clear drops every in-flight read so none is ever reported.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign out_valid = stage_q[DEPTH-1].valid;
   assign out_id    = stage_q[DEPTH-1].id;

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter in front of one single-ported unified memory.
// Priority DBG > DM > IF, with IF promoted above DM after a bounded run of
// denials. Read responses are steered back to their originator through a
// tag pipeline whose depth equals the memory read latency.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = MEM_LATENCY_DEFAULT,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                    clk,
   input  logic                    reset,

   input  logic                    dbg_req,
   input  logic                    dbg_we,
   input  logic [ADDR_WIDTH-1:0]   dbg_addr,
   input  logic [DATA_WIDTH-1:0]   dbg_wdata,
   output logic                    dbg_gnt,
   output logic                    dbg_rvalid,
   output logic [DATA_WIDTH-1:0]   dbg_rdata,

   input  logic                    dm_req,
   input  logic                    dm_we,
   input  logic [DATA_WIDTH/8-1:0] dm_be,
   input  logic [ADDR_WIDTH-1:0]   dm_addr,
   input  logic [DATA_WIDTH-1:0]   dm_wdata,
   output logic                    dm_gnt,
   output logic                    dm_rvalid,
   output logic [DATA_WIDTH-1:0]   dm_rdata,

   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic                    if_gnt,
   output logic                    if_rvalid,
   output logic [DATA_WIDTH-1:0]   if_rdata,

   output logic                    mem_req,
   output logic                    mem_we,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,

   output logic [CNT_WIDTH-1:0]    arb_conflicts
);

   localparam int BE_W  = DATA_WIDTH / 8;
   // Counter only needs to reach STARVE_LIMIT; keep at least one bit when disabled.
   localparam int STV_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

   arb_id_t              winner;
   logic                 promote;
   logic                 multi_req;
   logic                 tag_in_valid;
   logic                 tag_out_valid;
   logic [1:0]           tag_out_id;

   logic [STV_W-1:0]     starve_q;
   logic [STV_W-1:0]     starve_d;
   logic [CNT_WIDTH-1:0] conflicts_q;
   logic [CNT_WIDTH-1:0] conflicts_d;

   // IF jumps ahead of DM only once it has been denied STARVE_LIMIT cycles in a row.
   assign promote   = (STARVE_LIMIT != 0) && (starve_q == STV_MAX);
   assign multi_req = (dbg_req & dm_req) | (dbg_req & if_req) | (dm_req & if_req);

   // Pick this cycle's single winner from the live requests.
   always_comb begin
      winner = ARB_NONE;
      if (dbg_req) begin
         winner = ARB_DBG;
      end else if (dm_req && !(if_req && promote)) begin
         winner = ARB_DM;
      end else if (if_req) begin
         winner = ARB_IF;
      end
   end

   assign dbg_gnt = (winner == ARB_DBG);
   assign dm_gnt  = (winner == ARB_DM);
   assign if_gnt  = (winner == ARB_IF);
   assign mem_req = dbg_req | dm_req | if_req;

   // Steer the winner's payload to the memory; idle cycles drive all zeros.
   always_comb begin
      mem_we       = 1'b0;
      mem_be       = '0;
      mem_addr     = '0;
      mem_wdata    = '0;
      tag_in_valid = 1'b0;
      case (winner)
         ARB_DBG: begin
            mem_we       = dbg_we;
            mem_be       = {BE_W{1'b1}};
            mem_addr     = dbg_addr;
            mem_wdata    = dbg_wdata;
            tag_in_valid = !dbg_we;
         end
         ARB_DM: begin
            mem_we       = dm_we;
            mem_be       = dm_be;
            mem_addr     = dm_addr;
            mem_wdata    = dm_wdata;
            tag_in_valid = !dm_we;
         end
         ARB_IF: begin
            mem_we       = 1'b0;
            mem_be       = {BE_W{1'b1}};
            mem_addr     = if_addr;
            tag_in_valid = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Count consecutive denied IF cycles, saturating at the limit.
   always_comb begin
      starve_d = starve_q;
      if (!if_req || if_gnt) begin
         starve_d = '0;
      end else if (starve_q != STV_MAX) begin
         starve_d = starve_q + STV_W'(1);
      end
   end

   // Cycles with more than one requester; free-running and wrapping.
   always_comb begin
      conflicts_d = conflicts_q;
      if (multi_req) begin
         conflicts_d = conflicts_q + CNT_WIDTH'(1);
      end
   end

   // Arbitration state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_q    <= '0;
         conflicts_q <= '0;
      end else begin
         starve_q    <= starve_d;
         conflicts_q <= conflicts_d;
      end
   end

   assign arb_conflicts = conflicts_q;

   arb_tag_pipe #(
      .DEPTH (MEM_LATENCY)
   ) u_tag_pipe (
      .clk       (clk),
      .clr_n     (reset),
      .in_valid  (tag_in_valid),
      .in_id     (winner),
      .out_valid (tag_out_valid),
      .out_id    (tag_out_id)
   );

   // The exiting tag names the owner of mem_rdata; everyone else sees zero.
   assign dbg_rvalid = tag_out_valid && (tag_out_id == ARB_DBG);
   assign dm_rvalid  = tag_out_valid && (tag_out_id == ARB_DM);
   assign if_rvalid  = tag_out_valid && (tag_out_id == ARB_IF);

   assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
   assign dm_rdata   = dm_rvalid  ? mem_rdata : '0;
   assign if_rdata   = if_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 16-word memory behind the DUT, and a
// transaction-level reference (grant rule, response queue, word array).
module tb_mem_port_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int LAT  = 3;
   localparam int SLIM = 4;
   localparam int CW   = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          dbg_req, dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_gnt, dbg_rvalid;
   logic [DW-1:0] dbg_rdata;
   logic          dm_req, dm_we;
   logic [3:0]    dm_be;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_gnt, dm_rvalid;
   logic [DW-1:0] dm_rdata;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt, if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          mem_req, mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [CW-1:0] arb_conflicts;

   mem_port_arbiter #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .MEM_LATENCY  (LAT),
      .STARVE_LIMIT (SLIM),
      .CNT_WIDTH    (CW)
   ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .dbg_req       (dbg_req),
      .dbg_we        (dbg_we),
      .dbg_addr      (dbg_addr),
      .dbg_wdata     (dbg_wdata),
      .dbg_gnt       (dbg_gnt),
      .dbg_rvalid    (dbg_rvalid),
      .dbg_rdata     (dbg_rdata),
      .dm_req        (dm_req),
      .dm_we         (dm_we),
      .dm_be         (dm_be),
      .dm_addr       (dm_addr),
      .dm_wdata      (dm_wdata),
      .dm_gnt        (dm_gnt),
      .dm_rvalid     (dm_rvalid),
      .dm_rdata      (dm_rdata),
      .if_req        (if_req),
      .if_addr       (if_addr),
      .if_gnt        (if_gnt),
      .if_rvalid     (if_rvalid),
      .if_rdata      (if_rdata),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_be        (mem_be),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .arb_conflicts (arb_conflicts)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   // Memory behind the DUT: fixed read latency, garbage on non-read cycles.
   logic [31:0] env_mem  [16];
   logic [31:0] env_pipe [LAT];
   always @(posedge clk) begin
      if (mem_req && mem_we)
         env_mem[mem_addr[5:2]] <= be_merge(env_mem[mem_addr[5:2]], mem_wdata, mem_be);
      env_pipe[0] <= (mem_req && !mem_we) ? env_mem[mem_addr[5:2]] : $urandom;
      for (int i = 1; i < LAT; i++) env_pipe[i] <= env_pipe[i-1];
   end
   assign mem_rdata = env_pipe[LAT-1];

   // Reference state.
   typedef struct {
      int          due;
      int          port;   // 1 dbg, 2 dm, 3 if
      logic [31:0] data;
   } rsp_t;
   rsp_t        m_q[$];
   logic [31:0] m_mem [16];
   int          m_starve;
   int unsigned m_conf;
   int          m_w;       // 0 none, 1 dbg, 2 dm, 3 if
   int          cyc;
   int          n_chk, n_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic eval();
      bit          prom;
      int          nreq;
      int          rp;
      logic [31:0] rd;
      #1;
      nreq = int'(dbg_req) + int'(dm_req) + int'(if_req);
      prom = (SLIM != 0) && (m_starve == SLIM);
      if (dbg_req)                        m_w = 1;
      else if (dm_req && !(if_req && prom)) m_w = 2;
      else if (if_req)                    m_w = 3;
      else                                m_w = 0;
      chk("dbg_gnt", dbg_gnt, m_w == 1);
      chk("dm_gnt",  dm_gnt,  m_w == 2);
      chk("if_gnt",  if_gnt,  m_w == 3);
      chk("mem_req", mem_req, nreq > 0);
      case (m_w)
         0: begin
            chk("idle_we", mem_we, 0);     chk("idle_be", mem_be, 0);
            chk("idle_addr", mem_addr, 0); chk("idle_wdata", mem_wdata, 0);
         end
         1: begin
            chk("dbg_mem_we", mem_we, dbg_we);       chk("dbg_mem_be", mem_be, 4'hF);
            chk("dbg_mem_addr", mem_addr, dbg_addr); chk("dbg_mem_wdata", mem_wdata, dbg_wdata);
         end
         2: begin
            chk("dm_mem_we", mem_we, dm_we);       chk("dm_mem_be", mem_be, dm_be);
            chk("dm_mem_addr", mem_addr, dm_addr); chk("dm_mem_wdata", mem_wdata, dm_wdata);
         end
         default: begin
            chk("if_mem_we", mem_we, 0); chk("if_mem_addr", mem_addr, if_addr);
         end
      endcase
      rp = 0;
      rd = '0;
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
         rp = m_q[0].port;
         rd = m_q[0].data;
         void'(m_q.pop_front());
      end
      chk("dbg_rvalid", dbg_rvalid, rp == 1);
      chk("dm_rvalid",  dm_rvalid,  rp == 2);
      chk("if_rvalid",  if_rvalid,  rp == 3);
      chk("dbg_rdata",  dbg_rdata,  (rp == 1) ? rd : 32'h0);
      chk("dm_rdata",   dm_rdata,   (rp == 2) ? rd : 32'h0);
      chk("if_rdata",   if_rdata,   (rp == 3) ? rd : 32'h0);
      chk("arb_conflicts", arb_conflicts, m_conf);
   endtask

   // Advance the reference across one rising edge, then wait for the falling edge.
   task automatic edge_update();
      @(posedge clk);
      case (m_w)
         1: if (dbg_we) m_mem[dbg_addr[5:2]] = dbg_wdata;
            else m_q.push_back('{cyc + LAT, 1, m_mem[dbg_addr[5:2]]});
         2: if (dm_we) m_mem[dm_addr[5:2]] = be_merge(m_mem[dm_addr[5:2]], dm_wdata, dm_be);
            else m_q.push_back('{cyc + LAT, 2, m_mem[dm_addr[5:2]]});
         3: m_q.push_back('{cyc + LAT, 3, m_mem[if_addr[5:2]]});
         default: ;
      endcase
      if (if_req && m_w != 3) begin
         if (m_starve < SLIM) m_starve++;
      end else begin
         m_starve = 0;
      end
      if (int'(dbg_req) + int'(dm_req) + int'(if_req) > 1) m_conf++;
      cyc++;
      @(negedge clk);
   endtask

   task automatic tick();
      eval();
      edge_update();
   endtask

   task automatic all_idle();
      dbg_req = 1'b0;
      dm_req  = 1'b0;
      if_req  = 1'b0;
   endtask

   // Asynchronous reset from the middle of a cycle; outputs must clear at once.
   task automatic do_reset(input int cycles);
      reset = 1'b0;
      #1;
      chk("rst_dbg_rvalid", dbg_rvalid, 0);
      chk("rst_dm_rvalid",  dm_rvalid,  0);
      chk("rst_if_rvalid",  if_rvalid,  0);
      chk("rst_conflicts",  arb_conflicts, 0);
      m_q.delete();
      m_starve = 0;
      m_conf   = 0;
      repeat (cycles) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      int unsigned base;
      n_chk = 0; n_err = 0; cyc = 0; m_starve = 0; m_conf = 0; m_w = 0;
      reset = 1'b0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
      dm_req = 0; dm_we = 0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
      if_req = 0; if_addr = '0;
      repeat (2) @(negedge clk);
      chk("reset_conflicts", arb_conflicts, 0);
      chk("reset_if_rvalid", if_rvalid, 0);
      reset = 1'b1;
      tick();

      // Fill every memory word through the debug port.
      for (int i = 0; i < 16; i++) begin
         a = $urandom;
         a[5:2] = 4'(i);
         dbg_req = 1; dbg_we = 1; dbg_addr = a; dbg_wdata = $urandom;
         tick();
      end
      all_idle();

      // Single instruction fetch.
      dbg_req = 1; dbg_we = 1; dbg_addr = 32'h0; dbg_wdata = 32'h0050_0293;
      tick();
      all_idle();
      if_req = 1; if_addr = 32'h0;
      eval();
      chk("A_if_gnt", if_gnt, 1);
      edge_update();
      all_idle();
      for (int k = 1; k <= LAT; k++) begin
         eval();
         chk("A_if_rvalid", if_rvalid, k == LAT);
         if (k == LAT) chk("A_if_rdata", if_rdata, 32'h0050_0293);
         chk("A_dm_rvalid", dm_rvalid, 0);
         chk("A_dbg_rvalid", dbg_rvalid, 0);
         edge_update();
      end

      // DM beats IF, then IF wins once DM drops.
      base = m_conf;
      dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h14; if_req = 1; if_addr = 32'h8;
      eval();
      chk("B_dm_gnt", dm_gnt, 1);
      chk("B_if_gnt", if_gnt, 0);
      edge_update();
      dm_req = 0;
      eval();
      chk("B_if_gnt_next", if_gnt, 1);
      chk("B_conflicts", arb_conflicts, base + 1);
      edge_update();
      all_idle();
      repeat (LAT) tick();

      // IF starved by DM is promoted on the fifth cycle.
      base = m_conf;
      dm_req = 1; dm_we = 0; dm_addr = 32'h20; if_req = 1; if_addr = 32'h24;
      for (int k = 0; k < 6; k++) begin
         eval();
         chk("C_if_gnt", if_gnt, k == 4);
         chk("C_dm_gnt", dm_gnt, k != 4);
         if (k == 5) chk("C_conflicts", arb_conflicts, base + 5);
         edge_update();
      end
      all_idle();
      repeat (LAT + 1) tick();

      // Byte write followed by a read of the same word.
      dbg_req = 1; dbg_we = 1; dbg_addr = 32'h0; dbg_wdata = 32'h0;
      tick();
      all_idle();
      dm_req = 1; dm_we = 1; dm_be = 4'b0001; dm_addr = 32'h0; dm_wdata = 32'hFF;
      eval();
      chk("D_mem_we", mem_we, 1);
      chk("D_mem_be", mem_be, 4'b0001);
      edge_update();
      dm_we = 0;
      tick();
      all_idle();
      for (int k = 1; k <= LAT; k++) begin
         eval();
         chk("D_dm_rvalid", dm_rvalid, k == LAT);
         if (k == LAT) chk("D_dm_rdata", dm_rdata, 32'h0000_00FF);
         edge_update();
      end

      // Back-to-back reads from all three ports return in grant order.
      dbg_we = 0; dbg_addr = 32'h30; dm_we = 0; dm_addr = 32'h34; if_addr = 32'h38;
      for (int k = 0; k <= LAT + 2; k++) begin
         dbg_req = (k == 0);
         if_req  = (k == 1);
         dm_req  = (k == 2);
         eval();
         chk("E_dbg_rvalid", dbg_rvalid, k == LAT);
         chk("E_if_rvalid",  if_rvalid,  k == LAT + 1);
         chk("E_dm_rvalid",  dm_rvalid,  k == LAT + 2);
         edge_update();
      end
      all_idle();

      // Reset one cycle after a fetch grant: that fetch never completes.
      if_req = 1; if_addr = 32'h3C;
      tick();
      all_idle();
      do_reset(2);
      for (int k = 0; k < LAT + 2; k++) begin
         eval();
         chk("F_no_if_rvalid", if_rvalid, 0);
         edge_update();
      end
      if_req = 1; if_addr = 32'h0;
      tick();
      all_idle();
      for (int k = 1; k <= LAT; k++) begin
         eval();
         chk("F_if_rvalid", if_rvalid, k == LAT);
         edge_update();
      end

      // Reset while a response is on the output: rvalid drops without a clock.
      if_req = 1; if_addr = 32'h4;
      tick();
      all_idle();
      repeat (LAT - 1) tick();
      #1;
      chk("G_pre_if_rvalid", if_rvalid, 1);
      do_reset(1);
      repeat (LAT) tick();

      // Random traffic honouring hold-until-grant.
      for (int n = 0; n < 400; n++) begin
         if (!(dbg_req && m_w != 1 && $urandom_range(0, 15) != 0)) begin
            dbg_req = ($urandom_range(0, 7) == 0);
            dbg_we = 1'($urandom); dbg_addr = $urandom; dbg_wdata = $urandom;
         end
         if (!(dm_req && m_w != 2 && $urandom_range(0, 15) != 0)) begin
            dm_req = 1'($urandom);
            dm_we = 1'($urandom); dm_be = 4'($urandom_range(1, 15));
            dm_addr = $urandom; dm_wdata = $urandom;
         end
         if (!(if_req && m_w != 3 && $urandom_range(0, 15) != 0)) begin
            if_req = ($urandom_range(0, 3) != 0);
            if_addr = $urandom;
         end
         if (n == 200) do_reset(1);
         tick();
      end
      all_idle();
      repeat (LAT + 1) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between three requesters: debug/program-loader port (DBG), data-memory port from the MEM stage (DM), and instruction-fetch port (IF).
- Grants at most one request per cycle.
- Tracks in-flight reads through a fixed-latency tag pipeline and routes each response back to its originator.
- Bounds IF starvation.
- Exports a conflict counter for the performance-counter block.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8
MEM_LATENCY, 1, cycles from accepted read to mem_rdata valid; legal 1..4
STARVE_LIMIT, 4, consecutive denied IF cycles before IF is promoted; 0 disables promotion
CNT_WIDTH, 32, conflict counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
dbg_req  in  1  debug access request
dbg_we  in  1  debug write (1) / read (0)
dbg_addr  in  ADDR_WIDTH  debug address
dbg_wdata  in  DATA_WIDTH  debug write data (full-word writes, be=all ones)
dbg_gnt  out  1  debug request accepted this cycle
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  DATA_WIDTH  debug read data
dm_req  in  1  data request
dm_we  in  1  data write / read
dm_be  in  DATA_WIDTH/8  data byte enables
dm_addr  in  ADDR_WIDTH  data address
dm_wdata  in  DATA_WIDTH  data write data
dm_gnt  out  1  data request accepted
dm_rvalid  out  1  data read data valid
dm_rdata  out  DATA_WIDTH  data read data
if_req  in  1  fetch request (always read)
if_addr  in  ADDR_WIDTH  fetch address
if_gnt  out  1  fetch accepted
if_rvalid  out  1  fetch data valid
if_rdata  out  DATA_WIDTH  fetch data
mem_req  out  1  memory access strobe
mem_we  out  1  memory write
mem_be  out  DATA_WIDTH/8  memory byte enables
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after accepted read
arb_conflicts  out  CNT_WIDTH  count of cycles with at least one requester denied

Behaviour:
- Grant decision is combinational from the current-cycle requests.
- Priority: DBG > DM > IF.
  - Exception: when the promote flag is set, IF beats DM. DBG still wins.
- Exactly one of dbg_gnt, dm_gnt, if_gnt is high when any request is high; all are low otherwise.
- mem_* is a combinational mux of the winner. mem_req = OR of requests.
- When no request is high, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- IF and DM accesses use mem_we=0 for IF; DBG uses mem_be all ones.
- Requester holds req and its payload until gnt. A dropped req without gnt is legal and has no effect.
- Tag pipeline, MEM_LATENCY stages of {valid, id[1:0]}:
  - A granted read enters stage 0 at the clock edge.
  - Writes enter no tag and produce no rvalid.
- In the cycle a tag exits stage MEM_LATENCY-1:
  - the matching *_rvalid is 1;
  - that port's *_rdata = mem_rdata.
- Non-matching *_rdata = 0.
- Read response arrives exactly MEM_LATENCY cycles after the grant cycle.
- Back-to-back grants every cycle are supported; responses return in grant order.
- Starvation counter:
  - Increments each cycle with if_req=1 and if_gnt=0, saturating at STARVE_LIMIT.
  - Clears when if_gnt=1 or if_req=0.
- Promote flag = (counter == STARVE_LIMIT) and STARVE_LIMIT != 0.
- Conflict counter: arb_conflicts increments each cycle in which more than one req is high. Wraps at 2^CNT_WIDTH.
- Reset (reset=0, asynchronous):
  - All tag valids, the starvation counter and arb_conflicts go to 0.
  - All rvalids are low immediately.
  - Reads in flight at reset are discarded and never reported.
  - Grants remain combinational but the core must not rely on them during reset.
- Simultaneous grant and response: a new grant in the same cycle a tag exits is independent; both happen.

Decomposition:
- riscv_pkg additions:
  - typedef enum logic [1:0] arb_id_t {ARB_NONE, ARB_DBG, ARB_DM, ARB_IF};
  - localparam MEM_LATENCY_DEFAULT = 1;
  - localparam STARVE_LIMIT_DEFAULT = 4.
- One sub-module: arb_tag_pipe, a parameterised depth-MEM_LATENCY shift register of {valid, arb_id_t} with asynchronous active-low clear.
- Grant logic, starvation counter and conflict counter stay in the top.

Test Plan:
- Single reads:
  - IF read at addr 0x0 with mem returning 0x00500293 → if_gnt=1 same cycle, if_rvalid=1 and if_rdata=0x00500293 exactly 1 cycle later.
  - dm_rvalid and dbg_rvalid stay 0 throughout.
- Conflict and priority:
  - dm_req and if_req both high at cycle N → dm_gnt=1, if_gnt=0, arb_conflicts=1.
  - dm_req dropped at N+1 → if_gnt=1 at N+1.
- Starvation:
  - dm_req and if_req held high continuously with STARVE_LIMIT=4 → DM granted 4 cycles, IF granted on cycle 5, then DM resumes.
  - arb_conflicts=5 after 5 cycles.
- Write then read:
  - dm_we=1, dm_be=4'b0001, addr 0x0, wdata 0xFF → mem_we=1, mem_be=0001, no dm_rvalid.
  - Next-cycle DM read returns 0x000000FF with dm_rvalid.
- Latency and ordering:
  - MEM_LATENCY=3, grants DBG read, IF read, DM read on consecutive cycles → rvalids on cycles +3, +4, +5 in order dbg, if, dm.
  - Each rvalid carries the mem_rdata present that cycle.
- Reset mid-operation:
  - Assert reset low 1 cycle after an IF read grant (MEM_LATENCY=2) → no if_rvalid ever appears.
  - arb_conflicts=0; after reset release, a new IF read completes normally.
